// File: rtl/level_meter.sv
// Four-channel level meter: instant-attack envelope, held peak and sticky clip flags.
// Each clk_fs rise snapshots the inputs, then one channel is processed per clk_256fs cycle.
module level_meter #(
    parameter int W            = 16,
    parameter int DECAY_SHIFT  = 4,
    parameter int HOLD_SAMPLES = 4800,
    parameter int CLIP_LEVEL   = 2**(W-1) - 256
) (
    input  logic                clk_256fs,
    input  logic                rst_n,
    input  logic                clk_fs,
    input  logic signed [W-1:0] in0,
    input  logic signed [W-1:0] in1,
    input  logic signed [W-1:0] in2,
    input  logic signed [W-1:0] in3,
    input  logic                clip_clear,
    output logic [7:0]          level0,
    output logic [7:0]          level1,
    output logic [7:0]          level2,
    output logic [7:0]          level3,
    output logic [7:0]          peak0,
    output logic [7:0]          peak1,
    output logic [7:0]          peak2,
    output logic [7:0]          peak3,
    output logic [3:0]          clip,
    output logic                overrun,
    output logic                done
);
    localparam int HCW = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    localparam logic [HCW-1:0] HOLD_V = HCW'(HOLD_SAMPLES);
    localparam logic [W-2:0]   CLIP_V = (W-1)'(CLIP_LEVEL);
    localparam logic [W-2:0]   MAG_MAX = '1;
    localparam logic signed [W-1:0] IN_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SNAP, CH0, CH1, CH2, CH3, DONE} state_t;

    state_t                state_q, state_d;
    logic                  fs_q, fs_d;
    logic                  arm_q, arm_d;
    logic signed [W-1:0]   snap_q [4];
    logic signed [W-1:0]   snap_d [4];
    logic [W-2:0]          env_q [4];
    logic [W-2:0]          env_d [4];
    logic [W-2:0]          pk_q [4];
    logic [W-2:0]          pk_d [4];
    logic [HCW-1:0]        hc_q [4];
    logic [HCW-1:0]        hc_d [4];
    logic [7:0]            level_q [4];
    logic [7:0]            level_d [4];
    logic [7:0]            peak_q [4];
    logic [7:0]            peak_d [4];
    logic [3:0]            clip_q, clip_d;
    logic                  overrun_q, overrun_d;
    logic                  done_q, done_d;

    logic                  strobe;
    logic                  active;
    logic [1:0]            ch;
    logic signed [W-1:0]   x;
    logic [W-2:0]          mag;
    logic [W-2:0]          dec;
    logic [W-2:0]          env_new;
    logic [W-2:0]          pk_new;
    logic [HCW-1:0]        hc_new;

    always_comb begin
        // arm_q blocks a clk_fs that is already high when reset releases
        strobe    = clk_fs & ~fs_q & arm_q;
        fs_d      = clk_fs;
        arm_d     = arm_q | ~clk_fs;
        state_d   = state_q;
        snap_d    = snap_q;
        env_d     = env_q;
        pk_d      = pk_q;
        hc_d      = hc_q;
        level_d   = level_q;
        peak_d    = peak_q;
        clip_d    = clip_clear ? 4'b0000 : clip_q;
        overrun_d = clip_clear ? 1'b0 : overrun_q;
        active    = 1'b0;
        ch        = 2'd0;

        case (state_q)
            IDLE: if (strobe) state_d = SNAP;
            SNAP: begin
                snap_d[0] = in0;
                snap_d[1] = in1;
                snap_d[2] = in2;
                snap_d[3] = in3;
                state_d   = CH0;
            end
            CH0:  begin active = 1'b1; ch = 2'd0; state_d = CH1;  end
            CH1:  begin active = 1'b1; ch = 2'd1; state_d = CH2;  end
            CH2:  begin active = 1'b1; ch = 2'd2; state_d = CH3;  end
            CH3:  begin active = 1'b1; ch = 2'd3; state_d = DONE; end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (strobe && state_q != IDLE) overrun_d = 1'b1;

        x = snap_q[ch];
        if (x == IN_MIN)  mag = MAG_MAX;
        else if (x[W-1])  mag = (W-1)'(-x);
        else              mag = x[W-2:0];

        dec = env_q[ch] >> DECAY_SHIFT;
        if (dec == '0) dec = (W-1)'(1);
        if (mag >= env_q[ch])      env_new = mag;
        else if (env_q[ch] != '0)  env_new = env_q[ch] - dec;
        else                       env_new = env_q[ch];

        // Peak is held for HOLD_SAMPLES updates, then follows the input down
        if (mag >= pk_q[ch]) begin
            pk_new = mag;
            hc_new = HOLD_V;
        end else if (hc_q[ch] != '0) begin
            pk_new = pk_q[ch];
            hc_new = hc_q[ch] - HCW'(1);
        end else begin
            pk_new = mag;
            hc_new = hc_q[ch];
        end

        if (active) begin
            env_d[ch]   = env_new;
            pk_d[ch]    = pk_new;
            hc_d[ch]    = hc_new;
            level_d[ch] = env_new[W-2:W-9];
            peak_d[ch]  = pk_new[W-2:W-9];
            if (mag >= CLIP_V) clip_d[ch] = 1'b1;
        end

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fs_q      <= 1'b0;
            arm_q     <= 1'b0;
            clip_q    <= 4'b0000;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                snap_q[i]  <= '0;
                env_q[i]   <= '0;
                pk_q[i]    <= '0;
                hc_q[i]    <= '0;
                level_q[i] <= '0;
                peak_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            fs_q      <= fs_d;
            arm_q     <= arm_d;
            clip_q    <= clip_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
            snap_q    <= snap_d;
            env_q     <= env_d;
            pk_q      <= pk_d;
            hc_q      <= hc_d;
            level_q   <= level_d;
            peak_q    <= peak_d;
        end
    end

    assign level0  = level_q[0];
    assign level1  = level_q[1];
    assign level2  = level_q[2];
    assign level3  = level_q[3];
    assign peak0   = peak_q[0];
    assign peak1   = peak_q[1];
    assign peak2   = peak_q[2];
    assign peak3   = peak_q[3];
    assign clip    = clip_q;
    assign overrun = overrun_q;
    assign done    = done_q;

endmodule
